os_inst_sequencer: RTL and testbench
====================================

# os_inst_sequencer

Instruction sequencer for the output-stationary (OS) core. It replaces hand-driven instruction stimulus with a hardware FSM. On `start` it generates the 34-bit `inst` bus cycle by cycle in this order: weight stream XMEM→IFIFO, activation stream XMEM→L0, execution, then OFIFO readout. It sits directly in front of `core` and owns `inst` exclusively while busy.

## Interface
- `len`, 27: rows streamed per operand; XMEM words per weight/activation block.
- `row`, 8: array rows; sets the execute tail.
- `col`, 8: array columns; sets the execute tail.
- `o_feature_num`, 8: OFIFO words to pop.
- `W_BASE`, 11'h400: XMEM base address of the weights.
- `X_BASE`, 11'h000: XMEM base address of the activations.
- `DRAIN_MAX`, 64: cycle limit for waiting on OFIFO_valid.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `start` in 1: one-cycle request to run one full OS pass.
- `l0_ofifo_valid` in 5: core status. [4] OFIFO_valid, [2] OFIFO_full, [1] l0_full.
- `ififo_valid` in 3: core status. [0] IFIFO_full.
- `inst` out 34: core instruction bus. Field map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle pulse at the end of a pass.
- `out_valid` out 1: high in the cycle `sfp_out` holds a popped word.
- `overflow` out 1: sticky flag; a FIFO write was issued while the target was full.
- `timeout` out 1: sticky flag; DRAIN exceeded DRAIN_MAX.

## Operation
- All outputs are registered.
- IDLE `inst` value is 34'h1_800C_0000: CEN/WEN high for both memories, addresses 0, all strobes 0. acc, load, pmem and A_pmem hold this value in every state.
- States: IDLE → WLD → ALD → EXEC → DRAIN → READ → DONE → IDLE.
- IDLE: a `start` received while in IDLE enters WLD and clears `overflow`/`timeout`. `start` in any other state is ignored.
- WLD lasts len+1 cycles, indexed k = 0..len.
  - k < len: CEN_xmem = 0, WEN_xmem = 1, A_xmem = W_BASE + k.
  - ififo_wr = 1 for k ≥ 1, which matches the 1-cycle SRAM read latency.
  - Data in flight is never dropped. If IFIFO_full is high in a cycle where ififo_wr is issued, set `overflow` and continue.
- ALD: identical to WLD with base X_BASE and l0_wr instead of ififo_wr. l0_full sets `overflow` the same way.
- EXEC: l0_rd = ififo_rd = execute = 1 for exactly len + row + col cycles. XMEM is idle.
- DRAIN: all strobes are 0. Leave to READ in the cycle after OFIFO_valid is sampled high. If that does not happen within DRAIN_MAX cycles, set `timeout` and go to DONE.
- READ: ofifo_rd = OFIFO_valid (registered one cycle later onto `inst`).
  - Count issued pops; after o_feature_num pops go to DONE.
  - `out_valid` pulses one cycle after each issued ofifo_rd.
  - OFIFO_valid low stalls READ indefinitely. Only DRAIN has a timeout.
- DONE: `done` = 1 for one cycle, `busy` drops in the same cycle, `inst` returns to IDLE, next state IDLE.
- Counters are sized to clog2(len+row+col+1) or wider and must not wrap within a pass.
- A_xmem arithmetic is 11-bit modulo. W_BASE + len − 1 ≤ 11'h7FF is a parameter precondition, not checked.

## Timing
- Reset (reset = 0 at posedge): state = IDLE, counters = 0, `inst` = 34'h1_800C_0000, busy = done = out_valid = overflow = timeout = 0.
- Reset has priority over `start` in the same cycle.
- Mid-pass reset aborts within one cycle, with no further strobes.
- Start → first WLD `inst` (CEN_xmem = 0, A = W_BASE) appears on the posedge after the start sample.
- Phase transitions add no bubble cycles: the last WLD cycle is followed directly by ALD k = 0.
- Nominal pass length with OFIFO_valid immediately available is 2(len+1) + (len+row+col) + DRAIN + o_feature_num + 1 cycles.

## Test plan
- **Reset values:** hold reset = 0 for 3 cycles with start = 1 → `inst` = 34'h1_800C_0000, busy = 0, no state change.
- **Weight streaming:** start with defaults → 28 WLD cycles. A_xmem runs 0x400..0x41A with CEN = 0 on cycles 0..26, and ififo_wr = 1 on cycles 1..27. ALD then starts immediately at A_xmem = 0x000.
- **Execute window:** EXEC asserts execute/l0_rd/ififo_rd for exactly 43 cycles (27 + 8 + 8), then all drop.
- **Readout with stall:** model OFIFO_valid rising 5 cycles into DRAIN, low for 2 cycles mid-READ → exactly 8 ofifo_rd pulses, 8 out_valid pulses each lagging by 1, then a single done pulse.
- **Overflow:** hold IFIFO_full = 1 during WLD → overflow = 1 sticky, pass still completes, overflow cleared by the next accepted start.
- **Abort and ignore:** pull reset = 0 mid-EXEC → next cycle `inst` = idle value, busy = 0. Separately, OFIFO_valid never rises → timeout = 1 after 64 DRAIN cycles, done pulses. Start asserted while busy is ignored.

Source files
------------

// File: rtl/os_inst_sequencer.sv
// Instruction sequencer for the output-stationary core: drives the 34-bit inst bus
// through weight load, activation load, execute and OFIFO readout on each start.
module os_inst_sequencer #(
  parameter int          len           = 27,
  parameter int          row           = 8,
  parameter int          col           = 8,
  parameter int          o_feature_num = 8,
  parameter logic [10:0] W_BASE        = 11'h400,
  parameter logic [10:0] X_BASE        = 11'h000,
  parameter int          DRAIN_MAX     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  l0_ofifo_valid,
  input  logic [2:0]  ififo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic        overflow,
  output logic        timeout
);

  localparam int EXEC_LEN = len + row + col;
  localparam int MAX_A    = (EXEC_LEN > DRAIN_MAX) ? EXEC_LEN : DRAIN_MAX;
  localparam int MAX_B    = (o_feature_num > len + 1) ? o_feature_num : len + 1;
  localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_ALD, S_EXEC, S_DRAIN, S_READ, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [33:0]   inst_d;
  logic          busy_d, done_d;

  logic ofifo_valid, ofifo_full, l0_full, ififo_full;
  logic unused_status;

  assign ofifo_valid   = l0_ofifo_valid[4];
  assign ofifo_full    = l0_ofifo_valid[2];
  assign l0_full       = l0_ofifo_valid[1];
  assign ififo_full    = ififo_valid[0];
  assign unused_status = ^{l0_ofifo_valid[3], l0_ofifo_valid[0], ififo_valid[2:1], ofifo_full};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WLD;
          cnt_d   = '0;
        end
      end
      S_WLD: begin
        if (cnt_q == CW'(len)) begin
          state_d = S_ALD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ALD: begin
        if (cnt_q == CW'(len)) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (cnt_q == CW'(EXEC_LEN - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // READ counts issued pops only; a low OFIFO_valid simply stalls here.
      S_READ: begin
        if (ofifo_valid) begin
          if (cnt_q == CW'(o_feature_num - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d = INST_IDLE;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: busy_d = 1'b0;
      // ififo_wr/l0_wr trail the SRAM read by one cycle to match its latency.
      S_WLD: begin
        if (cnt_q < CW'(len)) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = W_BASE + 11'(cnt_q);
        end
        if (cnt_q != '0) inst_d[5] = 1'b1;
      end
      S_ALD: begin
        if (cnt_q < CW'(len)) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = X_BASE + 11'(cnt_q);
        end
        if (cnt_q != '0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        inst_d[4] = 1'b1;
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      S_DRAIN: inst_d = INST_IDLE;
      S_READ:  inst_d[6] = ofifo_valid;
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Status flags judge the strobes actually on the bus against the live full flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inst      <= INST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      inst      <= inst_d;
      busy      <= busy_d;
      done      <= done_d;
      out_valid <= inst[6];
      if (state_q == S_IDLE && start) begin
        overflow <= 1'b0;
        timeout  <= 1'b0;
      end else begin
        if ((inst[5] && ififo_full) || (inst[2] && l0_full)) overflow <= 1'b1;
        if (state_q == S_DRAIN && !ofifo_valid && cnt_q == CW'(DRAIN_MAX - 1)) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_os_inst_sequencer.sv
// Directed bench for os_inst_sequencer: four full passes logged cycle by cycle and
// compared against hand-derived cycle numbers for the default parameters.
module tb_os_inst_sequencer;

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;
  localparam logic [13:0] HI_IDLE   = 14'h1800;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  l0_ofifo_valid = 5'b0;
  logic [2:0]  ififo_valid = 3'b0;
  logic [33:0] inst;
  logic        busy, done, out_valid, overflow, timeout;

  int total = 0;
  int bad   = 0;

  logic [33:0] inst_log [0:299];
  logic        busy_log [0:299];
  logic        done_log [0:299];
  logic        outv_log [0:299];
  logic        ovf_log  [0:299];
  logic        to_log   [0:299];

  os_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .l0_ofifo_valid(l0_ofifo_valid), .ififo_valid(ififo_valid),
    .inst(inst), .busy(busy), .done(done), .out_valid(out_valid),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Per-cycle input schedule; index t is the negedge t cycles after the start sample.
  function automatic logic ofifoValid(input int mode, input int t);
    case (mode)
      0:       return (t >= 104) && (t != 108) && (t != 109);
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ififoFull(input int mode, input int t);
    return (mode == 1) && (t <= 30);
  endfunction

  function automatic logic l0Full(input int mode, input int t);
    return (mode == 2) && (t >= 29) && (t <= 56);
  endfunction

  task automatic driveInputs(input int mode, input int t);
    l0_ofifo_valid    = 5'b0;
    l0_ofifo_valid[4] = ofifoValid(mode, t);
    l0_ofifo_valid[1] = l0Full(mode, t);
    ififo_valid       = 3'b0;
    ififo_valid[0]    = ififoFull(mode, t);
    reset             = !((mode == 3) && (t >= 70) && (t < 75));
  endtask

  task automatic applyStimulus(input int mode, input int ncyc);
    @(negedge clk);
    start = 1'b1;
    driveInputs(mode, -1);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      inst_log[t] = inst;
      busy_log[t] = busy;
      done_log[t] = done;
      outv_log[t] = out_valid;
      ovf_log[t]  = overflow;
      to_log[t]   = timeout;
      start = (mode == 0) && (t == 50);
      driveInputs(mode, t);
    end
    start          = 1'b0;
    l0_ofifo_valid = 5'b0;
    ififo_valid    = 3'b0;
    reset          = 1'b1;
  endtask

  function automatic int countInst(input int b, input int lo, input int hi);
    int n = 0;
    for (int t = lo; t <= hi; t++) if (inst_log[t][b] === 1'b1) n++;
    return n;
  endfunction

  function automatic int countDone(input int lo, input int hi);
    int n = 0;
    for (int t = lo; t <= hi; t++) if (done_log[t] === 1'b1) n++;
    return n;
  endfunction

  function automatic int countOutValid(input int lo, input int hi);
    int n = 0;
    for (int t = lo; t <= hi; t++) if (outv_log[t] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int errs;
    logic [10:0] a;

    // Reset held with start high: bus must stay idle.
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_inst", inst, INST_IDLE);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_flags", {done, out_valid, overflow, timeout}, 0);
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_inst", inst, INST_IDLE);
    checkOutput("post_rst_busy", busy, 0);

    $display("[TB] pass A: defaults, OFIFO stall, ignored start");
    applyStimulus(0, 120);
    checkOutput("a_busy_rise", busy_log[1], 1);
    checkOutput("a_wld0_cen", inst_log[1][19], 0);
    checkOutput("a_wld0_addr", inst_log[1][17:7], 11'h400);
    checkOutput("a_wld0_wr", inst_log[1][5], 0);
    checkOutput("a_wld_last_cen", inst_log[28][19], 1);
    checkOutput("a_wld_last_wr", inst_log[28][5], 1);
    checkOutput("a_ald0_addr", inst_log[29][17:7], 11'h000);
    checkOutput("a_ald0_cen", inst_log[29][19], 0);
    checkOutput("a_ald0_wr", {inst_log[29][5], inst_log[29][2]}, 0);
    checkOutput("a_cen_low", 120 - countInst(19, 0, 119), 54);
    checkOutput("a_ififo_wr", countInst(5, 0, 119), 27);
    checkOutput("a_l0_wr", countInst(2, 0, 119), 27);
    checkOutput("a_exec_cnt", countInst(1, 0, 119), 43);
    checkOutput("a_l0_rd_cnt", countInst(3, 0, 119), 43);
    checkOutput("a_ififo_rd_cnt", countInst(4, 0, 119), 43);
    checkOutput("a_exec_edges", {inst_log[56][1], inst_log[57][1], inst_log[99][1], inst_log[100][1]}, 4'b0110);
    errs = 0;
    for (int t = 1; t <= 27; t++) begin
      a = 11'h400 + 11'(t - 1);
      if (inst_log[t][17:7] !== a) errs++;
    end
    for (int t = 29; t <= 55; t++) begin
      a = 11'(t - 29);
      if (inst_log[t][17:7] !== a) errs++;
    end
    checkOutput("a_addr_seq", errs, 0);
    errs = 0;
    for (int t = 0; t < 120; t++) if (inst_log[t][33:20] !== HI_IDLE) errs++;
    checkOutput("a_pmem_fixed", errs, 0);
    checkOutput("a_ofifo_rd", countInst(6, 0, 119), 8);
    checkOutput("a_stall", {inst_log[108][6], inst_log[109][6], inst_log[110][6], inst_log[111][6]}, 4'b1001);
    checkOutput("a_out_valid", countOutValid(0, 119), 8);
    errs = 0;
    for (int t = 1; t < 120; t++) if (outv_log[t] !== inst_log[t-1][6]) errs++;
    checkOutput("a_out_lag", errs, 0);
    checkOutput("a_done_cnt", countDone(0, 119), 1);
    checkOutput("a_done_at", done_log[116], 1);
    checkOutput("a_busy_end", {busy_log[115], busy_log[116]}, 2'b10);
    checkOutput("a_inst_end", inst_log[116], INST_IDLE);
    checkOutput("a_flags", {ovf_log[119], to_log[119]}, 0);

    $display("[TB] pass B: IFIFO full during weight load");
    applyStimulus(1, 115);
    checkOutput("b_overflow", ovf_log[30], 1);
    checkOutput("b_done_at", done_log[109], 1);
    checkOutput("b_busy_before_done", busy_log[108], 1);
    checkOutput("b_ofifo_rd", countInst(6, 0, 114), 8);
    checkOutput("b_out_valid", countOutValid(0, 114), 8);
    checkOutput("b_overflow_sticky", ovf_log[114], 1);

    $display("[TB] pass C: OFIFO never valid, L0 full during activation load");
    applyStimulus(2, 170);
    checkOutput("c_overflow_cleared", ovf_log[1], 0);
    checkOutput("c_l0_overflow", ovf_log[169], 1);
    checkOutput("c_timeout_early", to_log[162], 0);
    checkOutput("c_timeout_set", to_log[163], 1);
    checkOutput("c_done_at", done_log[164], 1);
    checkOutput("c_done_cnt", countDone(0, 169), 1);
    checkOutput("c_no_pops", countInst(6, 0, 169), 0);

    $display("[TB] pass D: reset mid-execute");
    applyStimulus(3, 80);
    checkOutput("d_timeout_cleared", to_log[5], 0);
    checkOutput("d_in_exec", inst_log[70][1], 1);
    checkOutput("d_abort_inst", inst_log[71], INST_IDLE);
    checkOutput("d_abort_busy", busy_log[71], 0);
    checkOutput("d_no_strobes", countInst(1, 71, 79) + countInst(3, 71, 79), 0);
    checkOutput("d_stay_idle", {busy_log[79], done_log[79]}, 0);
    checkOutput("d_idle_inst", inst_log[79], INST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
